// File: rtl/axi4_rw_pkg.sv
// Shared definitions for the AXI4 read/write splitter: counter sizing and response codes.
package axi4_rw_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bits needed to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/axi4_rw_splitter_if.sv
// Full AXI4 bundle (AW/W/B/AR/R) with master and slave views.
interface axi4_rw_splitter_if #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int IW = 5
) ();

  logic [AW-1:0]   aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic            aw_lock;
  logic [3:0]      aw_cache;
  logic [2:0]      aw_prot;
  logic [3:0]      aw_qos;
  logic [IW-1:0]   aw_id;
  logic            aw_valid;
  logic            aw_ready;

  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_last;
  logic            w_valid;
  logic            w_ready;

  logic [IW-1:0]   b_id;
  logic [1:0]      b_resp;
  logic            b_valid;
  logic            b_ready;

  logic [AW-1:0]   ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic            ar_lock;
  logic [3:0]      ar_cache;
  logic [2:0]      ar_prot;
  logic [3:0]      ar_qos;
  logic [IW-1:0]   ar_id;
  logic            ar_valid;
  logic            ar_ready;

  logic [IW-1:0]   r_id;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_last;
  logic            r_valid;
  logic            r_ready;

  modport master (
    output aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_id, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_id, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_id, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_id, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi4_outstanding_ctr.sv
// Saturating outstanding-burst counter with a sticky underflow flag.
module axi4_outstanding_ctr #(
  parameter int MAX_OUT = 8,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          underflow
);

  assign full = (count == CW'(MAX_OUT));

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: count <= count + CW'(1);
        2'b01: begin
          // A completion with nothing outstanding is a protocol error; hold at zero.
          if (count == '0) underflow <= 1'b1;
          else             count     <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi4_rw_splitter.sv
// Splits one AXI4 slave port into write-only and read-only masters with per-direction
// outstanding limits. Define AXI_RW_ORDER_EN to stop reads overtaking unacknowledged writes.
module axi4_rw_splitter
  import axi4_rw_pkg::*;
#(
  parameter int  MAX_OUT = 8,
  localparam int CW      = cnt_w(MAX_OUT)
) (
  input  logic               clk,
  input  logic               resetn,
  axi4_rw_splitter_if.slave  s_axi,
  axi4_rw_splitter_if.master m_wr,
  axi4_rw_splitter_if.master m_rd,
  output logic [CW-1:0]      wr_outstanding,
  output logic [CW-1:0]      rd_outstanding,
  output logic               err_underflow
);

  logic [1:0] rst_sync;
  logic       rst_int_n;
  logic       wr_full, rd_full, wr_uf, rd_uf;
  logic       order_ok_w, order_ok_r;
  logic       aw_ok, ar_ok, aw_gate, ar_gate;
  logic       aw_committed, ar_committed;
  logic       wr_inc, wr_dec, rd_inc, rd_dec;

  // NOTE: reset asserts asynchronously but releases on a clock edge so no flop sees a
  // deassertion racing the clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

`ifdef AXI_RW_ORDER_EN
  // A presenting AW outranks a waiting AR; a committed AR blocks new writes until accepted.
  assign order_ok_w = (rd_outstanding == '0) & ~ar_committed;
  assign order_ok_r = (wr_outstanding == '0) & ~s_axi.aw_valid;
`else
  assign order_ok_w = 1'b1;
  assign order_ok_r = 1'b1;
`endif

  assign aw_ok   = ~wr_full & order_ok_w;
  assign ar_ok   = ~rd_full & order_ok_r;
  assign aw_gate = rst_int_n & (aw_ok | aw_committed);
  assign ar_gate = rst_int_n & (ar_ok | ar_committed);

  // Once VALID is shown downstream it must stay up until the handshake.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      aw_committed <= 1'b0;
      ar_committed <= 1'b0;
    end else begin
      aw_committed <= m_wr.aw_valid & ~m_wr.aw_ready;
      ar_committed <= m_rd.ar_valid & ~m_rd.ar_ready;
    end
  end

  // Write address channel.
  assign m_wr.aw_addr  = s_axi.aw_addr;
  assign m_wr.aw_len   = s_axi.aw_len;
  assign m_wr.aw_size  = s_axi.aw_size;
  assign m_wr.aw_burst = s_axi.aw_burst;
  assign m_wr.aw_lock  = s_axi.aw_lock;
  assign m_wr.aw_cache = s_axi.aw_cache;
  assign m_wr.aw_prot  = s_axi.aw_prot;
  assign m_wr.aw_qos   = s_axi.aw_qos;
  assign m_wr.aw_id    = s_axi.aw_id;
  assign m_wr.aw_valid = s_axi.aw_valid & aw_gate;
  assign s_axi.aw_ready = m_wr.aw_ready & aw_gate;

  // Write data and response.
  assign m_wr.w_data   = s_axi.w_data;
  assign m_wr.w_strb   = s_axi.w_strb;
  assign m_wr.w_last   = s_axi.w_last;
  assign m_wr.w_valid  = s_axi.w_valid & rst_int_n;
  assign s_axi.w_ready = m_wr.w_ready & rst_int_n;
  assign s_axi.b_id    = m_wr.b_id;
  assign s_axi.b_resp  = m_wr.b_resp;
  assign s_axi.b_valid = m_wr.b_valid & rst_int_n;
  assign m_wr.b_ready  = s_axi.b_ready & rst_int_n;

  // Read address channel.
  assign m_rd.ar_addr  = s_axi.ar_addr;
  assign m_rd.ar_len   = s_axi.ar_len;
  assign m_rd.ar_size  = s_axi.ar_size;
  assign m_rd.ar_burst = s_axi.ar_burst;
  assign m_rd.ar_lock  = s_axi.ar_lock;
  assign m_rd.ar_cache = s_axi.ar_cache;
  assign m_rd.ar_prot  = s_axi.ar_prot;
  assign m_rd.ar_qos   = s_axi.ar_qos;
  assign m_rd.ar_id    = s_axi.ar_id;
  assign m_rd.ar_valid = s_axi.ar_valid & ar_gate;
  assign s_axi.ar_ready = m_rd.ar_ready & ar_gate;

  // Read data.
  assign s_axi.r_id    = m_rd.r_id;
  assign s_axi.r_data  = m_rd.r_data;
  assign s_axi.r_resp  = m_rd.r_resp;
  assign s_axi.r_last  = m_rd.r_last;
  assign s_axi.r_valid = m_rd.r_valid & rst_int_n;
  assign m_rd.r_ready  = s_axi.r_ready & rst_int_n;

  // The write master never reads and the read master never writes.
  assign m_wr.ar_addr  = '0;
  assign m_wr.ar_len   = '0;
  assign m_wr.ar_size  = '0;
  assign m_wr.ar_burst = '0;
  assign m_wr.ar_lock  = 1'b0;
  assign m_wr.ar_cache = '0;
  assign m_wr.ar_prot  = '0;
  assign m_wr.ar_qos   = '0;
  assign m_wr.ar_id    = '0;
  assign m_wr.ar_valid = 1'b0;
  assign m_wr.r_ready  = 1'b0;
  assign m_rd.aw_addr  = '0;
  assign m_rd.aw_len   = '0;
  assign m_rd.aw_size  = '0;
  assign m_rd.aw_burst = '0;
  assign m_rd.aw_lock  = 1'b0;
  assign m_rd.aw_cache = '0;
  assign m_rd.aw_prot  = '0;
  assign m_rd.aw_qos   = '0;
  assign m_rd.aw_id    = '0;
  assign m_rd.aw_valid = 1'b0;
  assign m_rd.w_data   = '0;
  assign m_rd.w_strb   = '0;
  assign m_rd.w_last   = 1'b0;
  assign m_rd.w_valid  = 1'b0;
  assign m_rd.b_ready  = 1'b0;

  assign wr_inc = m_wr.aw_valid & m_wr.aw_ready;
  assign wr_dec = s_axi.b_valid & s_axi.b_ready;
  assign rd_inc = m_rd.ar_valid & m_rd.ar_ready;
  assign rd_dec = s_axi.r_valid & s_axi.r_ready & s_axi.r_last;

  axi4_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CW(CW)) u_wr_ctr (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .inc       (wr_inc),
    .dec       (wr_dec),
    .count     (wr_outstanding),
    .full      (wr_full),
    .underflow (wr_uf)
  );

  axi4_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CW(CW)) u_rd_ctr (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .inc       (rd_inc),
    .dec       (rd_dec),
    .count     (rd_outstanding),
    .full      (rd_full),
    .underflow (rd_uf)
  );

  assign err_underflow = wr_uf | rd_uf;

endmodule

// File: tb/tb_axi4_rw_splitter.sv
// Directed self-checking bench for axi4_rw_splitter (MAX_OUT = 8); follows AXI_RW_ORDER_EN.
module tb_axi4_rw_splitter;
  import axi4_rw_pkg::*;

  localparam int MAX_OUT = 8;
  localparam int CW      = cnt_w(MAX_OUT);

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic          err_underflow;
  int            n_cmp = 0;
  int            n_err = 0;

  axi4_rw_splitter_if #(.DW(512), .AW(64), .IW(5)) s  ();
  axi4_rw_splitter_if #(.DW(512), .AW(64), .IW(5)) mw ();
  axi4_rw_splitter_if #(.DW(512), .AW(64), .IW(5)) mr ();

  axi4_rw_splitter #(.MAX_OUT(MAX_OUT)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .s_axi          (s),
    .m_wr           (mw),
    .m_rd           (mr),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    s.aw_addr = '0; s.aw_len = '0; s.aw_size = 3'd6; s.aw_burst = 2'b01; s.aw_lock = 1'b0;
    s.aw_cache = '0; s.aw_prot = '0; s.aw_qos = '0; s.aw_id = '0; s.aw_valid = 1'b0;
    s.w_data = '0; s.w_strb = '0; s.w_last = 1'b0; s.w_valid = 1'b0; s.b_ready = 1'b0;
    s.ar_addr = '0; s.ar_len = '0; s.ar_size = 3'd6; s.ar_burst = 2'b01; s.ar_lock = 1'b0;
    s.ar_cache = '0; s.ar_prot = '0; s.ar_qos = '0; s.ar_id = '0; s.ar_valid = 1'b0;
    s.r_ready = 1'b0;
    mw.aw_ready = 1'b0; mw.w_ready = 1'b0; mw.b_id = '0; mw.b_resp = '0; mw.b_valid = 1'b0;
    mw.ar_ready = 1'b0; mw.r_id = '0; mw.r_data = '0; mw.r_resp = '0; mw.r_last = 1'b0;
    mw.r_valid = 1'b0;
    mr.aw_ready = 1'b0; mr.w_ready = 1'b0; mr.b_id = '0; mr.b_resp = '0; mr.b_valid = 1'b0;
    mr.ar_ready = 1'b0; mr.r_id = '0; mr.r_data = '0; mr.r_resp = '0; mr.r_last = 1'b0;
    mr.r_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] wd;
    logic [511:0] rd;
    idle_inputs();

    // Reset: outputs forced low even with valid/ready presented.
    #3 resetn = 1'b0;
    @(negedge clk);
    s.aw_valid = 1'b1; mw.aw_ready = 1'b1; s.w_valid = 1'b1; mw.w_ready = 1'b1;
    #1;
    check("rst_m_awvalid", mw.aw_valid, 1'b0);
    check("rst_s_awready", s.aw_ready, 1'b0);
    check("rst_m_wvalid", mw.w_valid, 1'b0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_cnt", wr_outstanding, 0);
    check("rst_rd_cnt", rd_outstanding, 0);
    check("rst_err", err_underflow, 0);

    // 1: single write burst, len=3.
    @(negedge clk);
    s.aw_valid = 1'b1; s.aw_addr = 64'h1000_0000_0000_0040; s.aw_len = 8'd3; s.aw_id = 5'h0A;
    s.aw_qos = 4'h5; mw.aw_ready = 1'b1;
    #1;
    check("t1_m_awvalid", mw.aw_valid, 1'b1);
    check("t1_s_awready", s.aw_ready, 1'b1);
    check("t1_awaddr", mw.aw_addr, 64'h1000_0000_0000_0040);
    check("t1_awlen", mw.aw_len, 8'd3);
    check("t1_awid", mw.aw_id, 5'h0A);
    check("t1_awqos", mw.aw_qos, 4'h5);
    @(negedge clk);
    s.aw_valid = 1'b0;
    #1 check("t1_cnt_1", wr_outstanding, 1);
    mw.w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wd = {16{32'hA5A5_0000 | 32'(i)}};
      s.w_valid = 1'b1; s.w_data = wd; s.w_strb = '1; s.w_last = (i == 3);
      #1;
      check("t1_wdata", mw.w_data, wd);
      check("t1_wlast", mw.w_last, (i == 3));
      check("t1_wvalid", mw.w_valid, 1'b1);
    end
    check("t1_wstrb", mw.w_strb, {64{1'b1}});
    @(negedge clk);
    s.w_valid = 1'b0; s.w_last = 1'b0;
    mw.b_valid = 1'b1; mw.b_resp = RESP_OKAY; mw.b_id = 5'h0A; s.b_ready = 1'b1;
    #1;
    check("t1_bvalid", s.b_valid, 1'b1);
    check("t1_bresp", s.b_resp, RESP_OKAY);
    check("t1_bid", s.b_id, 5'h0A);
    check("t1_bready", mw.b_ready, 1'b1);
    @(negedge clk);
    mw.b_valid = 1'b0;
    #1 check("t1_cnt_0", wr_outstanding, 0);

    // 2: fill to MAX_OUT with B held off; the ninth AW stalls.
    @(negedge clk);
    s.aw_valid = 1'b1; s.aw_id = 5'h01;
    for (int i = 0; i < MAX_OUT; i++) begin
      #1 check("t2_accept", s.aw_ready, 1'b1);
      @(negedge clk);
    end
    #1;
    check("t2_full_cnt", wr_outstanding, MAX_OUT);
    check("t2_full_awready", s.aw_ready, 1'b0);
    check("t2_full_awvalid", mw.aw_valid, 1'b0);
    mw.b_valid = 1'b1; mw.b_resp = RESP_OKAY;
    #1 check("t2_no_same_cycle", s.aw_ready, 1'b0);
    @(negedge clk);
    mw.b_valid = 1'b0;
    #1;
    check("t2_after_b_cnt", wr_outstanding, MAX_OUT - 1);
    check("t2_released", s.aw_ready, 1'b1);
    check("t2_released_v", mw.aw_valid, 1'b1);
    @(negedge clk);
    s.aw_valid = 1'b0;
    #1 check("t2_refill", wr_outstanding, MAX_OUT);
    mw.b_valid = 1'b1;
    repeat (5) @(negedge clk);
    mw.b_valid = 1'b0;
    #1 check("t3_start_cnt", wr_outstanding, 3);

    // 3: AW handshake and B completion together at count 3.
    s.aw_valid = 1'b1; mw.b_valid = 1'b1;
    #1;
    check("t3_awready", s.aw_ready, 1'b1);
    check("t3_bvalid", s.b_valid, 1'b1);
    @(negedge clk);
    s.aw_valid = 1'b0; mw.b_valid = 1'b0;
    #1 check("t3_cnt_same", wr_outstanding, 3);
    mw.b_valid = 1'b1;
    repeat (3) @(negedge clk);
    mw.b_valid = 1'b0;
    #1 check("t3_drain", wr_outstanding, 0);

    // 4: AR issued while a write is outstanding.
    @(negedge clk);
    s.aw_valid = 1'b1;
    @(negedge clk);
    s.aw_valid = 1'b0;
    s.ar_valid = 1'b1; s.ar_addr = 64'h0000_2000_0000_0080; s.ar_len = 8'd1; s.ar_id = 5'h13;
    mr.ar_ready = 1'b1;
    #1;
    check("t4_wr_cnt", wr_outstanding, 1);
`ifdef AXI_RW_ORDER_EN
    check("t4_ar_blocked", mr.ar_valid, 1'b0);
    check("t4_ar_nready", s.ar_ready, 1'b0);
    @(negedge clk);
    mw.b_valid = 1'b1;
    #1 check("t4_ar_blocked_b", mr.ar_valid, 1'b0);
    @(negedge clk);
    mw.b_valid = 1'b0;
    #1;
    check("t4_ar_fwd", mr.ar_valid, 1'b1);
    check("t4_rd_cnt_0", rd_outstanding, 0);
`else
    check("t4_ar_fwd", mr.ar_valid, 1'b1);
    check("t4_ar_ready", s.ar_ready, 1'b1);
    @(negedge clk);
    s.ar_valid = 1'b0; mw.b_valid = 1'b1;
    #1 check("t4_rd_cnt_1", rd_outstanding, 1);
    @(negedge clk);
    mw.b_valid = 1'b0;
`endif
    check("t4_araddr", mr.ar_addr, 64'h0000_2000_0000_0080);
    check("t4_arid", mr.ar_id, 5'h13);
    @(negedge clk);
    s.ar_valid = 1'b0;
    #1;
    check("t4_rd_cnt", rd_outstanding, 1);
    check("t4_wr_cnt_0", wr_outstanding, 0);
    rd = {8{64'hC0DE_0000_1234_5678}};
    mr.r_valid = 1'b1; mr.r_data = rd; mr.r_resp = RESP_SLVERR; mr.r_id = 5'h13; mr.r_last = 1'b0;
    s.r_ready = 1'b1;
    #1;
    check("t4_rdata", s.r_data, rd);
    check("t4_rresp", s.r_resp, RESP_SLVERR);
    check("t4_rready", mr.r_ready, 1'b1);
    @(negedge clk);
    mr.r_last = 1'b1;
    #1;
    check("t4_mid_cnt", rd_outstanding, 1);
    check("t4_rlast", s.r_last, 1'b1);
    @(negedge clk);
    mr.r_valid = 1'b0; mr.r_last = 1'b0;
    #1 check("t4_rd_done", rd_outstanding, 0);

    // 5: stray B with nothing outstanding.
    mw.b_valid = 1'b1;
    @(negedge clk);
    mw.b_valid = 1'b0;
    #1;
    check("t5_err", err_underflow, 1'b1);
    check("t5_cnt_0", wr_outstanding, 0);
    s.aw_valid = 1'b1;
    @(negedge clk);
    s.aw_valid = 1'b0;
    #1 check("t5_cnt_1", wr_outstanding, 1);
    mw.b_valid = 1'b1;
    @(negedge clk);
    mw.b_valid = 1'b0;
    #1;
    check("t5_cnt_back", wr_outstanding, 0);
    check("t5_err_sticky", err_underflow, 1'b1);

    // 6: reset mid-burst at count 5.
    s.aw_valid = 1'b1;
    repeat (5) @(negedge clk);
    s.w_valid = 1'b1; mw.w_ready = 1'b1; mw.aw_ready = 1'b0;
    #1;
    check("t6_cnt_5", wr_outstanding, 5);
    check("t6_wvalid_pre", mw.w_valid, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check("t6_m_awvalid", mw.aw_valid, 1'b0);
    check("t6_s_awready", s.aw_ready, 1'b0);
    check("t6_m_wvalid", mw.w_valid, 1'b0);
    check("t6_s_wready", s.w_ready, 1'b0);
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t6_wr_cnt", wr_outstanding, 0);
    check("t6_rd_cnt", rd_outstanding, 0);
    check("t6_err", err_underflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
